// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction control FSM: fetch, decode, execute, memory and
// write-back sequencing with a memory-wait timeout, halt state and retired-instruction counter.
module ctrl_fsm #(
    parameter int OP_W    = 3,
    parameter int ULAOP_W = 2,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [OP_W-1:0]    OPcode,
    input  logic               Zero,
    input  logic               MemPronta,
    input  logic               Continua,
    output logic               MemToReg,
    output logic               EscMem,
    output logic               LerMem,
    output logic               Branch,
    output logic               ULAFonte,
    output logic               EscReg,
    output logic               Jump,
    output logic               EscPc,
    output logic               MoveReg,
    output logic               RegDest,
    output logic               EscIR,
    output logic [ULAOP_W-1:0] ULAOp,
    output logic [2:0]         Estado,
    output logic               Halted,
    output logic               Erro,
    output logic [CNT_W-1:0]   InstrCount
);

    typedef enum logic [2:0] {
        BUSCA  = 3'd0,
        DECOD  = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        ESCR   = 3'd4,
        PARADO = 3'd5,
        ERRO   = 3'd6
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_JUMP = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_LW   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_ula;
    logic             w_upper_bad;
    logic             w_wait_hit;
    logic             w_retire;

    assign w_upper_bad = |(OPcode >> 3);
    assign w_wait_hit  = (r_wait == 8'(TIMEOUT - 1));
    assign w_retire    = (w_next == BUSCA) &&
                         (r_state == EXEC || r_state == MEM || r_state == ESCR);

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        w_next   = r_state;
        w_ula    = 2'b00;
        MemToReg = 1'b0;
        EscMem   = 1'b0;
        LerMem   = 1'b0;
        Branch   = 1'b0;
        ULAFonte = 1'b0;
        EscReg   = 1'b0;
        Jump     = 1'b0;
        EscPc    = 1'b0;
        MoveReg  = 1'b0;
        RegDest  = 1'b0;
        EscIR    = 1'b0;
        Halted   = 1'b0;
        Erro     = 1'b0;
        case (r_state)
            BUSCA: begin
                LerMem = 1'b1;
                if (MemPronta) begin
                    EscIR  = 1'b1;
                    EscPc  = 1'b1;
                    w_next = DECOD;
                end else if (w_wait_hit) begin
                    w_next = ERRO;
                end
            end
            DECOD: begin
                if (w_upper_bad)                  w_next = ERRO;
                else if (OPcode[2:0] == OP_HALT)  w_next = PARADO;
                else if (OPcode[2:0] == OP_MOVE)  w_next = ESCR;
                else                              w_next = EXEC;
            end
            EXEC: begin
                case (r_op)
                    OP_ADD:  begin ULAFonte = 1'b1; w_next = ESCR; end
                    OP_SLT:  begin w_ula = 2'b10; w_next = ESCR; end
                    OP_BEQ:  begin
                        w_ula  = 2'b01;
                        Branch = 1'b1;
                        EscPc  = Zero;
                        w_next = BUSCA;
                    end
                    OP_JUMP: begin Jump = 1'b1; EscPc = 1'b1; w_next = BUSCA; end
                    OP_SW, OP_LW: begin ULAFonte = 1'b1; w_next = MEM; end
                    default: w_next = ERRO;
                endcase
            end
            MEM: begin
                if (r_op == OP_LW || r_op == OP_SW) begin
                    LerMem = (r_op == OP_LW);
                    EscMem = (r_op == OP_SW);
                    if (MemPronta)       w_next = (r_op == OP_LW) ? ESCR : BUSCA;
                    else if (w_wait_hit) w_next = ERRO;
                end else begin
                    w_next = ERRO;
                end
            end
            ESCR: begin
                EscReg   = 1'b1;
                RegDest  = (r_op == OP_ADD) || (r_op == OP_SLT);
                MemToReg = (r_op == OP_LW);
                MoveReg  = (r_op == OP_MOVE);
                w_next   = BUSCA;
            end
            PARADO: begin
                Halted = 1'b1;
                if (Continua) w_next = BUSCA;
            end
            ERRO:    Erro   = 1'b1;
            default: w_next = ERRO;
        endcase
    end

    assign ULAOp      = ULAOP_W'(w_ula);
    assign Estado     = r_state;
    assign InstrCount = r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= BUSCA;
            r_op    <= 3'b000;
            r_wait  <= 8'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECOD) r_op <= OPcode[2:0];
            // The wait counter restarts on any state change so each wait is timed independently.
            if (w_next != r_state)
                r_wait <= 8'd0;
            else if ((r_state == BUSCA || r_state == MEM) && !MemPronta)
                r_wait <= r_wait + 8'd1;
            if (w_retire && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter OP_W, default 3: OPcode width, minimum 3; bits above [2:0] SHALL be zero for legal opcodes.
REQ-002 Parameter ULAOP_W, default 2: ULAOp width; codes zero-extended to it.
REQ-003 Parameter TIMEOUT, default 15: max cycles waiting on MemPronta before error, range 1-255.
REQ-004 Parameter CNT_W, default 16: retired-instruction counter width.
REQ-005 Clock  in  1  sole clock; all state updates on rising edge.
REQ-006 Reset  in  1  synchronous, active-high; priority over all other inputs.
REQ-007 OPcode  in  OP_W  instruction opcode, sampled in DECOD.
REQ-008 Zero  in  1  ALU zero flag, beq decision.
REQ-009 MemPronta  in  1  memory ready/done handshake.
REQ-010 Continua  in  1  resume from PARADO.
REQ-011 MemToReg, EscMem, LerMem, Branch, ULAFonte, EscReg, Jump, EscPc, MoveReg, RegDest, EscIR  out  1 each  datapath strobes/selects.
REQ-012 ULAOp  out  ULAOP_W  ALU operation select.
REQ-013 Estado  out  3  current state code; Halted, Erro  out  1 each; InstrCount  out  CNT_W.

Function
REQ-014 States SHALL be BUSCA=0, DECOD=1, EXEC=2, MEM=3, ESCR=4, PARADO=5, ERRO=6; code 7 SHALL go to ERRO.
REQ-015 Outputs SHALL be decoded from state and latched opcode; no output SHALL ever drive z or x; unlisted outputs are 0.
REQ-016 BUSCA: LerMem=1; on MemPronta, EscIR=1 and EscPc=1 same cycle, next DECOD; else stay.
REQ-017 DECOD: latch OPcode; 111 -> PARADO; 001 (move) -> ESCR; 000/010/011/100/101/110 -> EXEC; any upper bit set -> ERRO.
REQ-018 EXEC add(000): ULAOp=00, ULAFonte=1 -> ESCR; slt(010): ULAOp=10, ULAFonte=0 -> ESCR.
REQ-019 EXEC beq(011): ULAOp=01, ULAFonte=0, Branch=1, EscPc=Zero (combinational) -> BUSCA.
REQ-020 EXEC jump(100): Jump=1, EscPc=1 -> BUSCA; lw(110)/sw(101): ULAOp=00, ULAFonte=1 -> MEM.
REQ-021 MEM: lw LerMem=1, sw EscMem=1, held until MemPronta; then sw -> BUSCA, lw -> ESCR.
REQ-022 ESCR: EscReg=1; add/slt RegDest=1, MemToReg=0; lw MemToReg=1, RegDest=0; move MoveReg=1, RegDest=0; -> BUSCA.
REQ-023 Latency with MemPronta already high: move/beq/jump 3 cycles, add/slt/sw 4, lw 5.
REQ-024 Wait counter SHALL clear on every state entry, increment each BUSCA/MEM cycle without MemPronta; reaching TIMEOUT SHALL go to ERRO; MemPronta on that same cycle SHALL win.
REQ-025 InstrCount SHALL increment by 1 on each transition into BUSCA from EXEC, MEM or ESCR, and saturate at all-ones.
REQ-026 PARADO: Halted=1, all strobes 0; Continua -> BUSCA; InstrCount unchanged.
REQ-027 ERRO: Erro=1, all strobes 0; sticky until Reset; Continua ignored.

Reset
REQ-028 On Reset high at edge: state BUSCA, wait counter 0, latched opcode 0, InstrCount 0, Erro 0, Halted 0.
REQ-029 Reset mid-operation (e.g. in MEM with EscMem=1) SHALL drop all strobes except BUSCA's LerMem the following cycle; no partial write completes.
REQ-030 Reset and Continua together SHALL yield BUSCA with counters cleared.

Verification
REQ-031 Reset, MemPronta=1, OPcode=000 -> Estado 0,1,2,4,0; EscReg=1 only in ESCR with RegDest=1; InstrCount=1.
REQ-032 OPcode=011, Zero=1 then Zero=0 -> EscPc=1 in EXEC first, 0 second; Branch=1 both; 3 cycles each.
REQ-033 OPcode=110, MemPronta low 3 cycles in MEM -> LerMem held 3 cycles, then ESCR with MemToReg=1; total 8 cycles.
REQ-034 MemPronta held low in BUSCA, TIMEOUT=15 -> Erro=1 at cycle 15; Continua=1 has no effect; Reset clears.
REQ-035 OPcode=111 -> PARADO, Halted=1, strobes 0 for 10 cycles; Continua pulse -> BUSCA next cycle.
REQ-036 OP_W=4, OPcode=1000 -> ERRO from DECOD; InstrCount CNT_W=2 after 5 adds saturates at 3.
